spi_op_sequencer: RTL and testbench

Parametrised SPI transaction sequencer for the arithmetic coprocessor. It is the successor to the single-operation multiply FSM.
- Receives an opcode followed by NUM_OPS operands MSB-first on MOSI.
- Presents them in parallel to the execution unit and pulses start.
- Waits for done, with a timeout.
- Shifts the result out on MISO.
- Additions over the predecessor: parametrised widths, operand count and opcode, chip-select abort, and execution timeout with an error flag.

---
 rtl/spi_op_sequencer_pkg.sv | 28 ++
 rtl/spi_op_sequencer_bit_counter.sv | 33 +++
 rtl/spi_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_spi_op_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_op_sequencer_pkg.sv
// rtl/spi_op_sequencer_pkg.sv - shared state encoding, shift modes and sizing helper
//
// Purpose: types and constants shared by spi_op_sequencer and its counter.
// Ports:   none (package).

package spi_op_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_OPC   = 3'd1,
        ST_RX_OPND  = 3'd2,
        ST_EXEC     = 3'd3,
        ST_LOAD_RES = 3'd4,
        ST_TX_RES   = 3'd5
    } state_t;

    // Shift-register modes, same meaning as the existing shift-register blocks.
    localparam logic [1:0] SH_HOLD  = 2'd0;
    localparam logic [1:0] SH_LEFT  = 2'd1;
    localparam logic [1:0] SH_PLOAD = 2'd2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_op_sequencer_bit_counter.sv
// rtl/spi_op_sequencer_bit_counter.sv - up-counter with clear, enable and terminal compare
//
// Purpose: shared counter for bit counting and the execution timeout.
// Ports:   clk, reset (async, active-high), clr (sync clear, wins over en),
//          en (count up), term (compare value), count, hit (count == term).

module spi_bit_counter
    import spi_op_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             hit
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign hit = (count == term);

endmodule

// File: rtl/spi_op_sequencer.sv
// rtl/spi_op_sequencer.sv - SPI opcode/operand receiver, exec handshake and result sender
//
// Purpose: receive opcode + NUM_OPS operands MSB-first, pulse start, wait for
//          done (with timeout), then shift the result out on miso.
// Ports:   clk, reset (async, active-high), cs, sclk_rise/sclk_fall strobes,
//          mosi, miso, miso_oe, opcode, operands, start, done, result, err,
//          abort, busy.

module spi_op_sequencer
    import spi_op_sequencer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_OPS = 2,
    parameter int OPC_W   = 2,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cs,
    input  logic                      sclk_rise,
    input  logic                      sclk_fall,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    output logic [OPC_W-1:0]          opcode,
    output logic [NUM_OPS*DATA_W-1:0] operands,
    output logic                      start,
    input  logic                      done,
    input  logic [RES_W-1:0]          result,
    output logic                      err,
    output logic                      abort,
    output logic                      busy
);

    localparam int OPND_W = NUM_OPS * DATA_W;
    localparam int BIT_W  = $clog2(max3(OPC_W, OPND_W, RES_W) + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    state_t state, nxt;

    logic [OPC_W-1:0]  opc_sh;
    logic [OPND_W-1:0] opnd_sh;
    logic [RES_W-1:0]  tx_sh;
    logic              armed;      // cs has been seen low since the last transaction

    logic [BIT_W-1:0]  bit_count, bit_term;
    logic              bit_hit, bit_en;
    logic [TO_W-1:0]   to_count;
    logic              to_hit, t_first;

    logic              opc_shift, opnd_shift, timeout_fire, err_clr;
    logic [1:0]        tx_mode;

    spi_bit_counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (nxt != state),
        .en    (bit_en),
        .term  (bit_term),
        .count (bit_count),
        .hit   (bit_hit)
    );

    // Runs only in EXEC, so it reads 0 in the first EXEC cycle.
    spi_bit_counter #(.WIDTH(TO_W)) u_to_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_EXEC),
        .en    (state == ST_EXEC),
        .term  (TO_W'(TIMEOUT - 1)),
        .count (to_count),
        .hit   (to_hit)
    );

    assign t_first = (to_count == '0);

    always_comb begin
        case (state)
            ST_RX_OPC:  bit_term = BIT_W'(OPC_W - 1);
            ST_RX_OPND: bit_term = BIT_W'(OPND_W - 1);
            default:    bit_term = BIT_W'(RES_W - 1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (state != ST_IDLE && !cs) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (cs && armed) nxt = ST_RX_OPC;
                ST_RX_OPC:   if (sclk_rise && bit_hit) nxt = ST_RX_OPND;
                ST_RX_OPND:  if (sclk_rise && bit_hit) nxt = ST_EXEC;
                ST_EXEC:     if ((done && !t_first) || to_hit) nxt = ST_LOAD_RES;
                ST_LOAD_RES: nxt = ST_TX_RES;
                ST_TX_RES:   if (sclk_fall && bit_hit) nxt = ST_IDLE;
                default:     nxt = ST_IDLE;
            endcase
        end
    end

    // cs low overrides every action in a non-idle state.
    always_comb begin
        start        = 1'b0;
        miso_oe      = 1'b0;
        opc_shift    = 1'b0;
        opnd_shift   = 1'b0;
        bit_en       = 1'b0;
        timeout_fire = 1'b0;
        err_clr      = 1'b0;
        tx_mode      = SH_HOLD;
        busy         = (state != ST_IDLE);
        abort        = (state != ST_IDLE) && !cs;
        case (state)
            ST_IDLE: begin
                err_clr = cs && armed;
            end
            ST_RX_OPC: begin
                opc_shift = cs && sclk_rise;
                bit_en    = cs && sclk_rise;
            end
            ST_RX_OPND: begin
                opnd_shift = cs && sclk_rise;
                bit_en     = cs && sclk_rise;
            end
            ST_EXEC: begin
                start        = cs && t_first;
                timeout_fire = cs && to_hit && !(done && !t_first);
            end
            ST_LOAD_RES: begin
                if (cs) tx_mode = SH_PLOAD;
            end
            ST_TX_RES: begin
                miso_oe = cs;
                bit_en  = cs && sclk_fall;
                if (cs && sclk_fall) tx_mode = SH_LEFT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opc_sh  <= '0;
            opnd_sh <= '0;
            tx_sh   <= '0;
            err     <= 1'b0;
            armed   <= 1'b1;
        end else begin
            if (opc_shift)  opc_sh  <= OPC_W'({opc_sh, mosi});
            if (opnd_shift) opnd_sh <= OPND_W'({opnd_sh, mosi});
            case (tx_mode)
                SH_PLOAD: tx_sh <= err ? '1 : result;
                SH_LEFT:  tx_sh <= RES_W'({tx_sh, 1'b0});
                default:  tx_sh <= tx_sh;
            endcase
            if (err_clr)           err <= 1'b0;
            else if (timeout_fire) err <= 1'b1;
            if (!cs)               armed <= 1'b1;
            else if (busy)         armed <= 1'b0;
        end
    end

    assign opcode   = opc_sh;
    assign operands = opnd_sh;
    assign miso     = tx_sh[RES_W-1];

endmodule

// File: tb/tb_spi_op_sequencer.sv
// tb/tb_spi_op_sequencer.sv - self-checking bench for spi_op_sequencer

module tb_spi_op_sequencer;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        sclk_rise = 1'b0;
    logic        sclk_fall = 1'b0;
    logic        mosi = 1'b0;
    logic        done = 1'b0;
    logic [15:0] result = 16'h0;
    logic        miso, miso_oe, start, err, abort, busy;
    logic [1:0]  opcode;
    logic [15:0] operands;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int abort_cnt = 0;
    int dly = 0;
    int exec_delay = 5;

    spi_op_sequencer #(
        .DATA_W(8), .NUM_OPS(2), .OPC_W(2), .RES_W(16), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .opcode(opcode), .operands(operands), .start(start), .done(done),
        .result(result), .err(err), .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_calc(input logic [1:0] opc, input logic [7:0] a,
                                             input logic [7:0] b);
        case (opc)
            2'd0:    return 16'(a) + 16'(b);
            2'd1:    return 16'(a) * 16'(b);
            2'd2:    return 16'(a) - 16'(b);
            default: return {a, b} ^ 16'h5AA5;
        endcase
    endfunction

    // Execution unit: raises done exec_delay clocks after start (0 = never).
    always @(posedge clk) begin
        #2;
        if (start) begin
            start_cnt++;
            done = 1'b0;
            dly = exec_delay;
        end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                done = 1'b1;
                result = ref_calc(opcode, operands[15:8], operands[7:0]);
            end
        end
        if (abort) abort_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [17:0] bits, input int n);
        for (int i = 17; i > 17 - n; i--) begin
            mosi = bits[i];
            sclk_rise = 1'b1;
            tick();
            sclk_rise = 1'b0;
            if (i > 0) tick();
        end
    endtask

    task automatic run_txn(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b,
                           input int delay, input int stop_bits, input string name);
        int s0, a0, cyc, err_cyc, exp_cyc, exp_err_cyc;
        logic got_oe;
        logic [15:0] val, exp_val;
        exec_delay = delay;
        s0 = start_cnt;
        a0 = abort_cnt;
        cs = 1'b0;
        tick();
        cs = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({busy, err} !== 2'b10) begin
            failures++;
            $display("FAIL %s entry: busy,err=%b want 10", name, {busy, err});
        end
        tick();
        send_bits({opc, a, b}, 18);
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || opcode !== opc || operands !== {a, b}) begin
            failures++;
            $display("FAIL %s capture: start=%b opc=%h opnd=%h want 1 %h %h",
                     name, start, opcode, operands, opc, {a, b});
        end
        cyc = 0;
        err_cyc = -1;
        got_oe = 1'b0;
        while (cyc < 400) begin
            tick();
            cyc++;
            @(negedge clk);
            if (err && err_cyc < 0) err_cyc = cyc;
            if (miso_oe) begin
                got_oe = 1'b1;
                break;
            end
        end
        exp_cyc = (delay == 0) ? TIMEOUT + 1 : delay + 2;
        exp_err_cyc = (delay == 0) ? TIMEOUT : -1;
        checks++;
        if (!got_oe || cyc != exp_cyc) begin
            failures++;
            $display("FAIL %s latency: miso_oe after %0d clk want %0d", name, cyc, exp_cyc);
            return;
        end
        checks++;
        if (err_cyc != exp_err_cyc) begin
            failures++;
            $display("FAIL %s err_time: err at %0d want %0d", name, err_cyc, exp_err_cyc);
        end
        val = 16'h0;
        for (int i = 0; i < stop_bits; i++) begin
            val = {val[14:0], miso};
            tick();
            sclk_fall = 1'b1;
            tick();
            sclk_fall = 1'b0;
            @(negedge clk);
        end
        if (stop_bits < 16) return;
        exp_val = (delay == 0) ? 16'hFFFF : ref_calc(opc, a, b);
        checks++;
        if (val !== exp_val) begin
            failures++;
            $display("FAIL %s miso_data: got %h want %h", name, val, exp_val);
        end
        checks++;
        if ({busy, miso_oe} !== 2'b00 || err !== (delay == 0)) begin
            failures++;
            $display("FAIL %s end: busy,oe,err=%b want 00%b", name, {busy, miso_oe, err},
                     delay == 0);
        end
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || start_cnt - s0 != 1 || abort_cnt != a0 || err !== (delay == 0)) begin
            failures++;
            $display("FAIL %s held_cs: busy=%b starts=%0d aborts=%0d err=%b want 0 1 0 %b",
                     name, busy, start_cnt - s0, abort_cnt - a0, err, delay == 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({busy, miso_oe, start, abort, err, miso} !== 6'b0 || opcode !== 2'b0
            || operands !== 16'h0) begin
            failures++;
            $display("FAIL reset: flags=%b opc=%h opnd=%h want 0 0 0",
                     {busy, miso_oe, start, abort, err, miso}, opcode, operands);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        run_txn(2'b01, 8'h0C, 8'h0A, 5, 16, "nominal");
    endtask

    task automatic test_timeout();
        run_txn(2'b10, 8'h33, 8'h11, 0, 16, "timeout");
        run_txn(2'b00, 8'h21, 8'h43, 3, 16, "after_timeout");
    endtask

    task automatic test_abort();
        int s0, a0;
        exec_delay = 5;
        s0 = start_cnt;
        a0 = abort_cnt;
        cs = 1'b0;
        tick();
        cs = 1'b1;
        tick();
        send_bits({2'b11, 8'hA5, 8'h00}, 7);
        cs = 1'b0;
        @(negedge clk);
        checks++;
        if ({abort, miso_oe, start} !== 3'b100) begin
            failures++;
            $display("FAIL abort_pulse: abort,oe,start=%b want 100", {abort, miso_oe, start});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({busy, abort} !== 2'b00 || abort_cnt - a0 != 1 || start_cnt != s0) begin
            failures++;
            $display("FAIL abort_idle: busy,abort=%b aborts=%0d starts=%0d want 00 1 0",
                     {busy, abort}, abort_cnt - a0, start_cnt - s0);
        end
        run_txn(2'b11, 8'h5C, 8'hE7, 4, 16, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_txn(2'b01, 8'hFF, 8'hFF, 2, 16, "b2b_first");
        run_txn(2'b10, 8'h01, 8'h80, 7, 16, "b2b_second");
    endtask

    task automatic test_reset_mid_tx();
        run_txn(2'b00, 8'h7F, 8'h9C, 5, 7, "reset_mid_tx");
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, miso_oe, start, abort, err, miso} !== 6'b0 || opcode !== 2'b0
            || operands !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: flags=%b opc=%h opnd=%h want 0 0 0",
                     {busy, miso_oe, start, abort, err, miso}, opcode, operands);
        end
        cs = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_txn(2'b01, 8'h13, 8'h07, 6, 16, "after_reset");
    endtask

    task automatic test_edge();
        int s0, a0;
        logic bad;
        exec_delay = 5;
        s0 = start_cnt;
        a0 = abort_cnt;
        cs = 1'b0;
        tick();
        cs = 1'b1;
        tick();
        send_bits({2'b01, 8'h09, 8'h09}, 18);
        repeat (5) tick();
        cs = 1'b0;
        @(negedge clk);
        checks++;
        if ({abort, miso_oe} !== 2'b10 || done !== 1'b1) begin
            failures++;
            $display("FAIL edge_abort: abort,oe,done=%b want 101", {abort, miso_oe, done});
        end
        bad = 1'b0;
        repeat (3) begin
            tick();
            @(negedge clk);
            if (miso_oe !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || start_cnt - s0 != 1 || abort_cnt - a0 != 1) begin
            failures++;
            $display("FAIL edge_after: bad=%b starts=%0d aborts=%0d want 0 1 1",
                     bad, start_cnt - s0, abort_cnt - a0);
        end
        run_txn(2'b10, 8'h90, 8'h0F, 5, 16, "after_edge");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_txn(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 12)), 16, "random");
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid_tx();
        test_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
